// File: rtl/vproc_div_lanes.sv
// -----------------------------------------------------------------------------
// vproc_div_lanes
//
// Multi-lane iterative radix-2 (restoring) divider for the vector DIV unit.
// Executes DIVU/DIV/REMU/REM on LANES independent W-bit elements in lock-step,
// with RISC-V divide-by-zero and signed-overflow results, per-lane masking and
// an opaque ID tag carried from request to result.
//
// Optional build macro:
//   VPROC_DIV_EARLY_TERM_EN - iterate only as many steps as the longest active
//                             dividend needs (pre-shifted dividends). Results
//                             are bit-identical to the fixed W-step build.
//
// Ports:
//   clk_i        clock
//   sync_rst_i   synchronous active-high reset
//   in_valid_i   request valid          in_ready_o   unit can accept
//   in_op_i      00=DIVU 01=DIV 10=REMU 11=REM
//   in_op1_i     dividends, lane k at [k*W +: W]
//   in_op2_i     divisors, same lane layout
//   in_mask_i    lane active flags      in_id_i      request tag
//   out_valid_o  result valid           out_ready_i  consumer accepts result
//   out_res_o    quotients/remainders (masked lanes read 0)
//   out_mask_o   mask of the request    out_id_o     tag of the request
// -----------------------------------------------------------------------------
module vproc_div_lanes #(
   parameter int unsigned W     = 32,
   parameter int unsigned LANES = 4,
   parameter int unsigned ID_W  = 4
) (
   input  logic               clk_i,
   input  logic               sync_rst_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [1:0]         in_op_i,
   input  logic [LANES*W-1:0] in_op1_i,
   input  logic [LANES*W-1:0] in_op2_i,
   input  logic [LANES-1:0]   in_mask_i,
   input  logic [ID_W-1:0]    in_id_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [LANES*W-1:0] out_res_o,
   output logic [LANES-1:0]   out_mask_o,
   output logic [ID_W-1:0]    out_id_o
);

   localparam int unsigned CNT_W = $clog2(W);

   localparam logic [W-1:0] ZERO_W   = {W{1'b0}};
   localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e                    state_r, state_s;
   logic                      accept_s;

   // Per-lane values derived from the incoming request
   logic [LANES-1:0][W-1:0]   ld_op1_s, ld_op2_s, ld_abs1_s, ld_abs2_s, ld_dq_s;
   logic [LANES-1:0]          ld_s1_s, ld_s2_s, ld_div0_s, ld_ovf_s;
   logic [CNT_W:0]            ld_shamt_s;
   logic [CNT_W-1:0]          ld_cnt_s;

   // Operation state
   logic [LANES-1:0][W-1:0]   op1_r, div_r, dq_r, rem_r;
   logic [LANES-1:0]          qsign_r, rsign_r, div0_r, ovf_r, mask_r;
   logic [ID_W-1:0]           id_r;
   logic                      rem_sel_r;
   logic [CNT_W-1:0]          cnt_r;

   // One restoring step plus final result formation
   logic [LANES-1:0][W:0]     rem_sh_s, rem_sub_s;
   logic [LANES-1:0][W-1:0]   rem_nx_s, dq_nx_s, quo_fix_s, rem_fix_s, res_s;
   logic [LANES-1:0]          qbit_s;

   // Registered outputs
   logic [LANES-1:0][W-1:0]   out_res_r;
   logic [LANES-1:0]          out_mask_r;
   logic [ID_W-1:0]           out_id_r;

   assign ld_op1_s    = in_op1_i;
   assign ld_op2_s    = in_op2_i;
   assign accept_s    = in_valid_i & in_ready_o;
   assign out_valid_o = (state_r == ST_DONE);
   assign out_res_o   = out_res_r;
   assign out_mask_o  = out_mask_r;
   assign out_id_o    = out_id_r;

   // Request decode: magnitudes, result signs and special-case flags per lane
   always_comb begin
      ld_s1_s   = {LANES{1'b0}};
      ld_s2_s   = {LANES{1'b0}};
      ld_div0_s = {LANES{1'b0}};
      ld_ovf_s  = {LANES{1'b0}};
      ld_abs1_s = {(LANES*W){1'b0}};
      ld_abs2_s = {(LANES*W){1'b0}};
      for (int k = 0; k < LANES; k++) begin
         ld_s1_s[k]   = in_op_i[0] & ld_op1_s[k][W-1];
         ld_s2_s[k]   = in_op_i[0] & ld_op2_s[k][W-1];
         ld_abs1_s[k] = ld_s1_s[k] ? (ZERO_W - ld_op1_s[k]) : ld_op1_s[k];
         ld_abs2_s[k] = ld_s2_s[k] ? (ZERO_W - ld_op2_s[k]) : ld_op2_s[k];
         ld_div0_s[k] = (ld_op2_s[k] == ZERO_W);
         ld_ovf_s[k]  = in_op_i[0] & (ld_op1_s[k] == MOST_NEG) & (ld_op2_s[k] == ALL_ONES);
      end
   end

`ifdef VPROC_DIV_EARLY_TERM_EN
   localparam logic [CNT_W:0] ONE_EXT = {{CNT_W{1'b0}}, 1'b1};
   localparam logic [CNT_W:0] W_EXT   = (CNT_W+1)'(W);

   logic [LANES-1:0][CNT_W:0] blen_s;
   logic [CNT_W:0]            bmax_s;

   function automatic logic [CNT_W:0] bit_len(input logic [W-1:0] v);
      logic [CNT_W:0] n;
      n = {(CNT_W+1){1'b0}};
      for (int i = 0; i < W; i++) begin
         n = v[i] ? (CNT_W+1)'(i + 1) : n;
      end
      return n;
   endfunction

   // Step count = longest dividend among lanes whose result comes from iteration
   always_comb begin
      bmax_s = ONE_EXT;
      blen_s = {(LANES*(CNT_W+1)){1'b0}};
      for (int k = 0; k < LANES; k++) begin
         blen_s[k] = bit_len(ld_abs1_s[k]);
         bmax_s    = (in_mask_i[k] && !ld_div0_s[k] && !ld_ovf_s[k] && (blen_s[k] > bmax_s))
                     ? blen_s[k] : bmax_s;
      end
      ld_shamt_s = W_EXT - bmax_s;
      ld_cnt_s   = CNT_W'(bmax_s - ONE_EXT);
   end
`else
   assign ld_shamt_s = {(CNT_W+1){1'b0}};
   assign ld_cnt_s   = CNT_W'(W - 1);
`endif

   // Dividends are left-aligned so the first step sees their top significant bit
   always_comb begin
      ld_dq_s = {(LANES*W){1'b0}};
      for (int k = 0; k < LANES; k++) begin
         ld_dq_s[k] = ld_abs1_s[k] << ld_shamt_s;
      end
   end

   // Restoring step; the shifted remainder needs W+1 bits before the compare
   always_comb begin
      rem_sh_s  = {(LANES*(W+1)){1'b0}};
      rem_sub_s = {(LANES*(W+1)){1'b0}};
      rem_nx_s  = {(LANES*W){1'b0}};
      dq_nx_s   = {(LANES*W){1'b0}};
      qbit_s    = {LANES{1'b0}};
      for (int k = 0; k < LANES; k++) begin
         rem_sh_s[k]  = {rem_r[k], dq_r[k][W-1]};
         rem_sub_s[k] = rem_sh_s[k] - {1'b0, div_r[k]};
         qbit_s[k]    = (rem_sh_s[k] >= {1'b0, div_r[k]});
         rem_nx_s[k]  = qbit_s[k] ? rem_sub_s[k][W-1:0] : rem_sh_s[k][W-1:0];
         dq_nx_s[k]   = {dq_r[k][W-2:0], qbit_s[k]};
      end
   end

   // Sign correction, special-case override and lane masking of the final step
   always_comb begin
      quo_fix_s = {(LANES*W){1'b0}};
      rem_fix_s = {(LANES*W){1'b0}};
      res_s     = {(LANES*W){1'b0}};
      for (int k = 0; k < LANES; k++) begin
         if (div0_r[k]) begin
            quo_fix_s[k] = ALL_ONES;
            rem_fix_s[k] = op1_r[k];
         end else if (ovf_r[k]) begin
            quo_fix_s[k] = op1_r[k];
            rem_fix_s[k] = ZERO_W;
         end else begin
            quo_fix_s[k] = qsign_r[k] ? (ZERO_W - dq_nx_s[k]) : dq_nx_s[k];
            rem_fix_s[k] = rsign_r[k] ? (ZERO_W - rem_nx_s[k]) : rem_nx_s[k];
         end
         if (!mask_r[k]) begin
            res_s[k] = ZERO_W;
         end else begin
            res_s[k] = rem_sel_r ? rem_fix_s[k] : quo_fix_s[k];
         end
      end
   end

   // Next-state and handshake logic
   always_comb begin
      state_s    = state_r;
      in_ready_o = 1'b0;
      case (state_r)
         ST_IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               state_s = ST_BUSY;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_BUSY;
            end
         end
         ST_DONE: begin
            // A consumed result frees the unit for a request in the same cycle
            in_ready_o = out_ready_i;
            if (out_ready_i && in_valid_i) begin
               state_s = ST_BUSY;
            end else if (out_ready_i) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, operand latching, iteration and result registers
   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         state_r    <= ST_IDLE;
         op1_r      <= {(LANES*W){1'b0}};
         div_r      <= {(LANES*W){1'b0}};
         dq_r       <= {(LANES*W){1'b0}};
         rem_r      <= {(LANES*W){1'b0}};
         qsign_r    <= {LANES{1'b0}};
         rsign_r    <= {LANES{1'b0}};
         div0_r     <= {LANES{1'b0}};
         ovf_r      <= {LANES{1'b0}};
         mask_r     <= {LANES{1'b0}};
         id_r       <= {ID_W{1'b0}};
         rem_sel_r  <= 1'b0;
         cnt_r      <= {CNT_W{1'b0}};
         out_res_r  <= {(LANES*W){1'b0}};
         out_mask_r <= {LANES{1'b0}};
         out_id_r   <= {ID_W{1'b0}};
      end else begin
         state_r <= state_s;
         if (accept_s) begin
            op1_r     <= ld_op1_s;
            div_r     <= ld_abs2_s;
            dq_r      <= ld_dq_s;
            rem_r     <= {(LANES*W){1'b0}};
            qsign_r   <= ld_s1_s ^ ld_s2_s;
            rsign_r   <= ld_s1_s;
            div0_r    <= ld_div0_s;
            ovf_r     <= ld_ovf_s;
            mask_r    <= in_mask_i;
            id_r      <= in_id_i;
            rem_sel_r <= in_op_i[1];
            cnt_r     <= ld_cnt_s;
         end else if (state_r == ST_BUSY) begin
            dq_r  <= dq_nx_s;
            rem_r <= rem_nx_s;
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if ((state_r == ST_BUSY) && (cnt_r == {CNT_W{1'b0}})) begin
            out_res_r  <= res_s;
            out_mask_r <= mask_r;
            out_id_r   <= id_r;
         end
      end
   end

endmodule

// File: tb/tb_vproc_div_lanes.sv
// -----------------------------------------------------------------------------
// tb_vproc_div_lanes
//
// Self-checking bench for vproc_div_lanes (W=32, LANES=4, ID_W=4). Expected
// results come from a behavioural model using plain integer division with the
// RISC-V divide-by-zero and overflow rules; expected latency is W, or the
// longest active dividend bit-length when VPROC_DIV_EARLY_TERM_EN is defined.
// -----------------------------------------------------------------------------
module tb_vproc_div_lanes;

   localparam int W     = 32;
   localparam int LANES = 4;
   localparam int ID_W  = 4;

   logic                clk;
   logic                sync_rst;
   logic                in_valid;
   logic                in_ready;
   logic [1:0]          in_op;
   logic [LANES*W-1:0]  in_op1;
   logic [LANES*W-1:0]  in_op2;
   logic [LANES-1:0]    in_mask;
   logic [ID_W-1:0]     in_id;
   logic                out_valid;
   logic                out_ready;
   logic [LANES*W-1:0]  out_res;
   logic [LANES-1:0]    out_mask;
   logic [ID_W-1:0]     out_id;

   int errors = 0;
   int checks = 0;

   vproc_div_lanes #(.W(W), .LANES(LANES), .ID_W(ID_W)) dut (
      .clk_i       (clk),
      .sync_rst_i  (sync_rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_op_i     (in_op),
      .in_op1_i    (in_op1),
      .in_op2_i    (in_op2),
      .in_mask_i   (in_mask),
      .in_id_i     (in_id),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_res_o   (out_res),
      .out_mask_o  (out_mask),
      .out_id_o    (out_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_lane(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      int sa, sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a;
         r = 32'd0;
      end else if (op[0]) begin
         sa = $signed(a);
         sb = $signed(b);
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
      return op[1] ? r : q;
   endfunction

   function automatic logic [127:0] ref_vec(input logic [1:0] op, input logic [127:0] a,
                                            input logic [127:0] b, input logic [3:0] m);
      logic [127:0] v;
      v = 128'd0;
      for (int k = 0; k < LANES; k++) begin
         v[k*32 +: 32] = m[k] ? ref_lane(op, a[k*32 +: 32], b[k*32 +: 32]) : 32'd0;
      end
      return v;
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [127:0] a,
                                  input logic [127:0] b, input logic [3:0] m);
`ifdef VPROC_DIV_EARLY_TERM_EN
      int best, bl;
      logic [31:0] x, y;
      longint unsigned mag;
      best = 1;
      for (int k = 0; k < LANES; k++) begin
         x = a[k*32 +: 32];
         y = b[k*32 +: 32];
         if (m[k] && y != 32'd0 && !(op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) begin
            mag = (op[0] && x[31]) ? longint'(64'd4294967296 - x) : longint'(x);
            bl = 0;
            while (mag != 0) begin
               bl++;
               mag = mag >> 1;
            end
            if (bl > best) best = bl;
         end
      end
      return best;
`else
      return W;
`endif
   endfunction

   function automatic logic [31:0] rand_opnd();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0: v = $urandom_range(0, 255);
         1: v = 32'd0;
         2: v = 32'h8000_0000;
         3: v = 32'hFFFF_FFFF;
         4: v = $urandom() >> $urandom_range(0, 31);
         default: v = $urandom();
      endcase
      return v;
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic send(input logic [1:0] op, input logic [127:0] a, input logic [127:0] b,
                       input logic [3:0] m, input logic [3:0] id);
      in_op = op; in_op1 = a; in_op2 = b; in_mask = m; in_id = id; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_op1   = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_op2   = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic wait_valid(output int lat);
      lat = -1;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (out_res !== 128'd0) begin errors++; $display("FAIL reset_out_res: got %h want 0", out_res); end
      checks++; if (out_mask !== 4'd0) begin errors++; $display("FAIL reset_out_mask: got %b want 0", out_mask); end
      checks++; if (out_id !== 4'd0) begin errors++; $display("FAIL reset_out_id: got %h want 0", out_id); end
   endtask

   task automatic test_divu();
      logic [127:0] a, b, exp;
      int lat;
      a = {32'd0, 32'd1000, 32'hFFFF_FFFF, 32'd100};
      b = {32'd5, 32'd3, 32'd1, 32'd7};
      exp = ref_vec(2'b00, a, b, 4'b1111);
      send(2'b00, a, b, 4'b1111, 4'd5);
      wait_valid(lat);
      checks++; if (lat !== W) begin errors++; $display("FAIL divu_latency: got %0d want %0d", lat, W); end
      checks++; if (out_res[31:0] !== 32'd14) begin errors++; $display("FAIL divu_lane0: got %h want 0000000e", out_res[31:0]); end
      checks++; if (out_res[63:32] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_lane1: got %h want ffffffff", out_res[63:32]); end
      checks++; if (out_res !== exp) begin errors++; $display("FAIL divu_all: got %h want %h", out_res, exp); end
      checks++; if (out_id !== 4'd5) begin errors++; $display("FAIL divu_id: got %h want 5", out_id); end
      checks++; if (out_mask !== 4'b1111) begin errors++; $display("FAIL divu_mask: got %b want 1111", out_mask); end
      release_out();
   endtask

   task automatic test_signs();
      logic [127:0] a, b, exp;
      int lat;
      a = {$urandom(), 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9};
      b = {$urandom() | 32'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd2};
      for (int o = 0; o < 4; o++) begin
         exp = ref_vec(2'(o), a, b, 4'b1111);
         send(2'(o), a, b, 4'b1111, 4'(o + 8));
         wait_valid(lat);
         checks++; if (lat !== exp_lat(2'(o), a, b, 4'b1111)) begin errors++; $display("FAIL signs_latency op%0d: got %0d want %0d", o, lat, exp_lat(2'(o), a, b, 4'b1111)); end
         checks++; if (out_res !== exp) begin errors++; $display("FAIL signs_res op%0d: got %h want %h", o, out_res, exp); end
         if (o == 1) begin
            checks++; if (out_res[63:0] !== {32'hFFFF_FFFD, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_neg7_by2: got %h want fffffffdfffffffd", out_res[63:0]); end
         end else if (o == 3) begin
            checks++; if (out_res[63:0] !== {32'd1, 32'hFFFF_FFFF}) begin errors++; $display("FAIL rem_signs: got %h want 00000001ffffffff", out_res[63:0]); end
         end
         release_out();
      end
   endtask

   task automatic test_special();
      logic [127:0] a, b, exp;
      int lat;
      a = {32'h8000_0000, 32'hFFFF_FFFB, 32'd9, 32'h8000_0000};
      b = {32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF};
      for (int o = 0; o < 4; o++) begin
         exp = ref_vec(2'(o), a, b, 4'b1111);
         send(2'(o), a, b, 4'b1111, 4'(o));
         wait_valid(lat);
         checks++; if (lat !== exp_lat(2'(o), a, b, 4'b1111)) begin errors++; $display("FAIL special_latency op%0d: got %0d want %0d", o, lat, exp_lat(2'(o), a, b, 4'b1111)); end
         checks++; if (out_res !== exp) begin errors++; $display("FAIL special_res op%0d: got %h want %h", o, out_res, exp); end
         case (o)
            0: begin checks++; if (out_res[63:32] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by0: got %h want ffffffff", out_res[63:32]); end end
            1: begin checks++; if (out_res[31:0] !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf: got %h want 80000000", out_res[31:0]); end end
            2: begin checks++; if (out_res[63:32] !== 32'd9) begin errors++; $display("FAIL remu_by0: got %h want 00000009", out_res[63:32]); end end
            default: begin checks++; if (out_res[31:0] !== 32'd0) begin errors++; $display("FAIL rem_ovf: got %h want 0", out_res[31:0]); end end
         endcase
         release_out();
      end
   endtask

   task automatic test_random();
      logic [127:0] a, b, exp;
      logic [1:0] op;
      logic [3:0] m, id;
      int lat;
      for (int n = 0; n < 24; n++) begin
         op = 2'($urandom_range(0, 3));
         m  = 4'($urandom_range(0, 15));
         id = 4'($urandom_range(0, 15));
         for (int k = 0; k < LANES; k++) begin
            a[k*32 +: 32] = rand_opnd();
            b[k*32 +: 32] = rand_opnd();
         end
         exp = ref_vec(op, a, b, m);
         send(op, a, b, m, id);
         wait_valid(lat);
         checks++; if (lat !== exp_lat(op, a, b, m)) begin errors++; $display("FAIL rand_latency #%0d: got %0d want %0d", n, lat, exp_lat(op, a, b, m)); end
         checks++; if (out_res !== exp) begin errors++; $display("FAIL rand_res #%0d op%0d: got %h want %h", n, op, out_res, exp); end
         checks++; if (out_id !== id || out_mask !== m) begin errors++; $display("FAIL rand_tag #%0d: got id %h mask %b want id %h mask %b", n, out_id, out_mask, id, m); end
         release_out();
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] a, b, a2, b2, exp, exp2, held;
      int lat, bad;
      a  = {32'd500, 32'd77, 32'd1234, 32'd99};
      b  = {32'd3, 32'd0, 32'd10, 32'd4};
      exp = ref_vec(2'b00, a, b, 4'b0101);
      send(2'b00, a, b, 4'b0101, 4'd3);
      wait_valid(lat);
      held = out_res;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || out_res !== held || in_ready !== 1'b0 || out_id !== 4'd3) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL backpressure_hold: got %0d unstable cycles want 0", bad); end
      checks++; if (held !== exp) begin errors++; $display("FAIL masked_res: got %h want %h", held, exp); end
      checks++; if (held[63:32] !== 32'd0 || held[127:96] !== 32'd0) begin errors++; $display("FAIL masked_lanes_zero: got %h want 0", {held[127:96], held[63:32]}); end
      a2 = {32'hFFFF_FF00, 32'd45, 32'h7FFF_FFFF, 32'hFFFF_FFF0};
      b2 = {32'd16, 32'hFFFF_FFF9, 32'd2, 32'd3};
      exp2 = ref_vec(2'b11, a2, b2, 4'b1111);
      in_op = 2'b11; in_op1 = a2; in_op2 = b2; in_mask = 4'b1111; in_id = 4'd12;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL done_in_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_busy: got out_valid %b want 0", out_valid); end
      wait_valid(lat);
      checks++; if (lat !== exp_lat(2'b11, a2, b2, 4'b1111)) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, exp_lat(2'b11, a2, b2, 4'b1111)); end
      checks++; if (out_res !== exp2 || out_id !== 4'd12) begin errors++; $display("FAIL b2b_res: got %h id %h want %h id c", out_res, out_id, exp2); end
      release_out();
   endtask

   task automatic test_reset_mid();
      logic [127:0] a, b, exp;
      int lat, seen;
      a = {4{32'hFFFF_FFFF}};
      b = {32'd3, 32'd5, 32'd7, 32'd9};
      send(2'b00, a, b, 4'b1111, 4'd7);
      repeat (9) @(posedge clk);
      #1 sync_rst = 1'b1;
      @(posedge clk); #1;
      sync_rst = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midreset_state: got ready %b valid %b want 1 0", in_ready, out_valid); end
      checks++; if (out_res !== 128'd0 || out_id !== 4'd0) begin errors++; $display("FAIL midreset_outputs: got %h id %h want 0", out_res, out_id); end
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL midreset_stale: got %0d valid cycles want 0", seen); end
      a = {32'd100, 32'd200, 32'd300, 32'd400};
      exp = ref_vec(2'b10, a, b, 4'b1111);
      send(2'b10, a, b, 4'b1111, 4'd6);
      wait_valid(lat);
      checks++; if (out_res !== exp) begin errors++; $display("FAIL postreset_res: got %h want %h", out_res, exp); end
      release_out();
   endtask

   task automatic test_early_term();
      logic [127:0] a, b, exp;
      int lat;
      a = {32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), 32'd200};
      b = {32'($urandom_range(1, 255)), 32'($urandom_range(1, 255)), 32'($urandom_range(1, 255)), 32'd9};
      exp = ref_vec(2'b00, a, b, 4'b1111);
      send(2'b00, a, b, 4'b1111, 4'd1);
      wait_valid(lat);
      checks++; if (lat !== exp_lat(2'b00, a, b, 4'b1111)) begin errors++; $display("FAIL et_latency: got %0d want %0d", lat, exp_lat(2'b00, a, b, 4'b1111)); end
      checks++; if (out_res !== exp) begin errors++; $display("FAIL et_res: got %h want %h", out_res, exp); end
      release_out();
      exp = 128'd0;
      send(2'b01, a, b, 4'b0000, 4'd2);
      wait_valid(lat);
      checks++; if (lat !== exp_lat(2'b01, a, b, 4'b0000)) begin errors++; $display("FAIL allmasked_latency: got %0d want %0d", lat, exp_lat(2'b01, a, b, 4'b0000)); end
      checks++; if (out_res !== exp || out_mask !== 4'b0000) begin errors++; $display("FAIL allmasked_res: got %h mask %b want 0", out_res, out_mask); end
      release_out();
   endtask

   initial begin
      sync_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_op = 2'b00; in_op1 = '0; in_op2 = '0; in_mask = 4'd0; in_id = 4'd0;
      repeat (3) @(posedge clk);
      #1 sync_rst = 1'b0;
      test_reset();
      test_divu();
      test_signs();
      test_special();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_early_term();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
